seq_pattern_detector: RTL

//  Parametrised serial bit-pattern detector; successor to the fixed "01" detector FSM.

---
 rtl/seq_pattern_detector.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seq_pattern_detector.sv
// ============================================================================
//  Module      : seq_pattern_detector
//  Description : Serial bit-pattern detector against a run-time loadable
//                PAT_LEN-bit pattern. It supports overlapping and
//                non-overlapping match modes and keeps a saturating match
//                counter. The optional macro SEQ_DET_MASK_EN adds a
//                don't-care mask (pat_mask_i) that is captured together with
//                the pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_detector #(
    parameter int                   PAT_LEN = 4,
    parameter int                   CNT_W   = 8,
    parameter logic [PAT_LEN-1:0]   RST_PAT = PAT_LEN'(4'b0101)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_i,
    input  logic                din_valid_i,
    input  logic [PAT_LEN-1:0]  pat_i,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_LEN-1:0]  pat_mask_i,
`endif
    input  logic                pat_load_i,
    input  logic                overlap_en_i,
    input  logic                clr_cnt_i,
    output logic                match_o,
    output logic [CNT_W-1:0]    match_cnt_o,
    output logic                cnt_sat_o,
    output logic                busy_armed_o
);

    localparam int FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic [PAT_LEN-1:0]  hist_q,  hist_d;
    logic [PAT_LEN-1:0]  pat_q,   pat_d;
    logic                match_q, match_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                sat_q,   sat_d;
    logic [PAT_LEN-1:0]  mask_w;
    logic [PAT_LEN-1:0]  hist_shift;
    logic                cmp_eq;
    logic                hit;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0]  mask_q, mask_d;
    assign mask_w = mask_q;
`else
    assign mask_w = '1;
`endif

    // History after accepting the current bit; this is what gets compared
    assign hist_shift = {hist_q[PAT_LEN-2:0], din_i};
    assign cmp_eq     = (((hist_shift ^ pat_q) & mask_w) == '0);

    // Next-state logic: pattern load, history shift, FSM, match and counter
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        hit     = 1'b0;
`ifdef SEQ_DET_MASK_EN
        mask_d  = mask_q;
`endif
        if (pat_load_i) begin
            // A load discards any concurrent data bit and re-arms from scratch
            pat_d   = pat_i;
`ifdef SEQ_DET_MASK_EN
            mask_d  = pat_mask_i;
`endif
            fill_d  = '0;
            state_d = FILL;
        end else if (din_valid_i) begin
            hist_d = hist_shift;
            case (state_q)
                FILL: begin
                    if (fill_q == FILL_W'(PAT_LEN - 1)) begin
                        state_d = ARMED;
                        fill_d  = '0;
                        hit     = cmp_eq;
                    end else begin
                        fill_d  = fill_q + 1'b1;
                    end
                end
                ARMED: begin
                    hit = cmp_eq;
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            endcase
            // Non-overlapping mode demands PAT_LEN fresh bits after a hit
            if (hit && !overlap_en_i) begin
                state_d = FILL;
                fill_d  = '0;
            end
        end
        match_d = hit;

        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            if (match_q && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == '1) begin
                sat_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_q   <= RST_PAT;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= '1;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign match_o      = match_q;
    assign match_cnt_o  = cnt_q;
    assign cnt_sat_o    = sat_q;
    assign busy_armed_o = (state_q == ARMED);

endmodule

`default_nettype wire
